// File: rtl/addseq_pkg.sv
// -----------------------------------------------------------------------------
// addseq_pkg
// Shared definitions for the byte-serial add/subtract sequencer:
//   - state_t          : FSM encoding (IDLE / RUN / DONE)
//   - SLICE_W          : width of the shared add slice
//   - NBYTES_MAX       : largest supported operand width in bytes
//   - CNT_W_MAX        : counter width needed at NBYTES_MAX
//   - cnt_width()      : byte-counter width for a given NBYTES, never below 1
//   - sat_max/sat_min(): signed saturation constants for a given width
// -----------------------------------------------------------------------------
package addseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SLICE_W    = 8;
    localparam int NBYTES_MAX = 16;
    localparam int CNT_W_MAX  = 4;
    localparam int SAT_W_MAX  = SLICE_W * NBYTES_MAX;

    // A single-byte operand still needs a 1-bit counter.
    function automatic int cnt_width(input int nbytes);
        if (nbytes <= 1) begin
            return 1;
        end else begin
            return $clog2(nbytes);
        end
    endfunction

    // Largest positive value of a w-bit signed number: 0x7F..F.
    function automatic logic [SAT_W_MAX-1:0] sat_max(input int w);
        logic [SAT_W_MAX-1:0] v;
        v = '0;
        for (int i = 0; i < SAT_W_MAX; i++) begin
            if (i < w - 1) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    // Most negative value of a w-bit signed number: 0x80..0.
    function automatic logic [SAT_W_MAX-1:0] sat_min(input int w);
        logic [SAT_W_MAX-1:0] v;
        v = '0;
        for (int i = 0; i < SAT_W_MAX; i++) begin
            if (i == w - 1) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/addseq_ctrl_byte_slice.sv
// -----------------------------------------------------------------------------
// addseq_byte_slice
// Purely combinational 8-bit ripple add with carry in.
//   a, b    : byte operands
//   cin     : carry into bit 0
//   sum     : 8-bit sum
//   cout    : carry out of bit 7
//   msb_cin : carry into bit 7 (XOR with cout gives signed overflow)
// -----------------------------------------------------------------------------
module addseq_byte_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout,
    output logic       msb_cin
);

    logic [7:0] lo_s;
    logic [1:0] hi_s;

    // Split at bit 7 so the carry into the MSB is visible for overflow.
    assign lo_s    = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'd0, cin};
    assign hi_s    = {1'b0, a[7]} + {1'b0, b[7]} + {1'b0, lo_s[7]};
    assign sum     = {hi_s[0], lo_s[6:0]};
    assign cout    = hi_s[1];
    assign msb_cin = lo_s[7];

endmodule

// File: rtl/addseq_ctrl.sv
// -----------------------------------------------------------------------------
// addseq_ctrl
// Byte-serial multi-precision add/subtract sequencer. One 8-bit add slice is
// time-shared LSB-first; the inter-byte carry lives in a flop.
// Optional feature macro: ADDSEQ_SAT_EN (signed saturation on overflow).
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake (a, b, sub sampled at accept)
//   a, b                 : W-bit operands, W = 8*NBYTES
//   sub                  : 0 = A+B, 1 = A-B
//   out_valid / out_ready: result handshake
//   s, cout, ovf         : result, final carry (sub: 1 = no borrow), signed ovf
//   busy                 : high while in RUN or DONE
// -----------------------------------------------------------------------------
module addseq_ctrl
    import addseq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic              sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [8*NBYTES-1:0] s,
    output logic              cout,
    output logic              ovf,
    output logic              busy
);

    localparam int W      = SLICE_W * NBYTES;
    localparam int TOP_SH = W - SLICE_W;
    localparam int CNT_W  = cnt_width(NBYTES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

`ifdef ADDSEQ_SAT_EN
    localparam logic [W-1:0] SAT_POS = W'(sat_max(W));
    localparam logic [W-1:0] SAT_NEG = W'(sat_min(W));
`endif

    state_t           state_r;
    logic [W-1:0]     a_sh_r;
    logic [W-1:0]     b_sh_r;
    logic             carry_r;
    logic [CNT_W-1:0] cnt_r;
    logic [W-1:0]     s_r;
    logic             cout_r;
    logic             ovf_r;

    logic [7:0]       sum_s;
    logic             c_s;
    logic             c7_s;
    logic             ovf_byte_s;
    logic [W-1:0]     res_shift_s;
    logic [W-1:0]     res_final_s;

    addseq_byte_slice u_slice (
        .a       (a_sh_r[7:0]),
        .b       (b_sh_r[7:0]),
        .cin     (carry_r),
        .sum     (sum_s),
        .cout    (c_s),
        .msb_cin (c7_s)
    );

    // Handshake and status outputs decode directly from the state register.
    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_DONE);
    assign busy      = (state_r == ST_RUN) || (state_r == ST_DONE);
    assign s         = s_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

    // Next result: new byte enters at the top, register shifts right 8.
    always_comb begin
        ovf_byte_s  = c7_s ^ c_s;
        res_shift_s = (s_r >> 4'd8) | (W'(sum_s) << TOP_SH);
`ifdef ADDSEQ_SAT_EN
        // On overflow both operand MSBs agree, so either gives the true sign.
        if (ovf_byte_s) begin
            res_final_s = a_sh_r[7] ? SAT_NEG : SAT_POS;
        end else begin
            res_final_s = res_shift_s;
        end
`else
        res_final_s = res_shift_s;
`endif
    end

    // Sequencer FSM with operand shift registers, carry flop and result regs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_sh_r  <= '0;
            b_sh_r  <= '0;
            carry_r <= 1'b0;
            cnt_r   <= '0;
            s_r     <= '0;
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtract as A + ~B + 1: the +1 rides in as carry-in.
                        a_sh_r  <= a;
                        b_sh_r  <= sub ? ~b : b;
                        carry_r <= sub;
                        cnt_r   <= '0;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_sh_r  <= a_sh_r >> 4'd8;
                    b_sh_r  <= b_sh_r >> 4'd8;
                    carry_r <= c_s;
                    if (cnt_r == CNT_LAST) begin
                        s_r     <= res_final_s;
                        cout_r  <= c_s;
                        ovf_r   <= ovf_byte_s;
                        state_r <= ST_DONE;
                    end else begin
                        s_r     <= res_shift_s;
                        cnt_r   <= cnt_r + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addseq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_addseq_ctrl
// Self-checking bench for addseq_ctrl with NBYTES=4: directed cases with
// constant expectations, then randomized operations against an arithmetic
// reference model. Build with +define+ADDSEQ_SAT_EN to cover saturation.
// -----------------------------------------------------------------------------
module tb_addseq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
    logic        busy;

    int errors = 0;
    int checks = 0;

    addseq_ctrl #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic and signed-range reasoning.
    task automatic model(input logic [31:0] x, input logic [31:0] y, input logic sb,
                         output logic [31:0] r, output logic c, output logic o);
        logic [32:0] t;
        if (sb) begin
            t = {1'b0, x} - {1'b0, y};
            r = t[31:0];
            c = (x >= y);
            o = (x[31] != y[31]) && (r[31] != x[31]);
        end else begin
            t = {1'b0, x} + {1'b0, y};
            r = t[31:0];
            c = t[32];
            o = (x[31] == y[31]) && (r[31] != x[31]);
        end
`ifdef ADDSEQ_SAT_EN
        if (o) begin
            r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, take it on the next edge, then scramble the inputs.
    task automatic start(input logic [31:0] x, input logic [31:0] y, input logic sb, input string tag);
        in_valid = 1'b1;
        a = x;
        b = y;
        sub = sb;
        chk({tag, "_in_ready_idle"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        sub = 1'($urandom_range(0, 1));
        chk({tag, "_busy_run"}, busy, 1'b1);
        chk({tag, "_in_ready_run"}, in_ready, 1'b0);
    endtask

    task automatic run(input logic [31:0] x, input logic [31:0] y, input logic sb,
                       input logic [31:0] es, input logic ec, input logic eo,
                       input int hold, input string tag);
        int lat;
        start(x, y, sb, tag);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            if (lat == 0) begin
                tick();
                if (out_valid) lat = i;
            end
        end
        chk({tag, "_latency"}, lat, 4);
        chk({tag, "_s"}, s, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_valid"}, out_valid, 1'b1);
            chk({tag, "_hold_s"}, s, es);
            chk({tag, "_hold_in_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 1'b0);
        chk({tag, "_in_ready_back"}, in_ready, 1'b1);
        chk({tag, "_s_held"}, s, es);
    endtask

    initial begin
        logic [31:0] rx, ry, rs;
        logic        rsb, rc, ro;

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_s", s, 32'd0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        tick();

        run(32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 0, "ripple");
        run(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 0, "chain");
`ifdef ADDSEQ_SAT_EN
        run(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 0, "ovf_sat");
        run(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 0, "ovf_sat_neg");
`else
        run(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 0, "ovf_wrap");
        run(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 0, "ovf_wrap_neg");
`endif
        run(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, "sub_borrow");
        run(32'h0000_0007, 32'h0000_0005, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 0, "sub_noborrow");

        // Backpressure, then an immediate new request on the following edge
        run(32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0, 10, "bp");
        run(32'h0000_0010, 32'h0000_0020, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 0, "bp_next");

        // Reset during the second RUN cycle
        start(32'h1234_5678, 32'h0000_0001, 1'b0, "abort");
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_s", s, 32'd0);
        chk("abort_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        run(32'h0000_0003, 32'h0000_0004, 1'b0, 32'h0000_0007, 1'b0, 1'b0, 0, "post_rst");

        // Randomized operations against the reference model
        for (int n = 0; n < 30; n++) begin
            rx  = $urandom;
            ry  = $urandom;
            rsb = 1'($urandom_range(0, 1));
            if (n % 5 == 0) ry = rx ^ 32'h8000_0000;
            model(rx, ry, rsb, rs, rc, ro);
            run(rx, ry, rsb, rs, rc, ro, $urandom_range(0, 3), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
